sata_cmd_sequencer: RTL
=======================

// Module: sata_cmd_sequencer
// PURPOSE
//  Issues one ATA command at a time through the controller's shadow-register host port (HOST_* bus).
//  Per command: writes FEATURES, COUNT, LBA_L, LBA_M, LBA_H, DEVICE and COMMAND; waits for IPF; reads STATUS.
//  Drives DMA_RQST for DMA opcodes, bounds each command with a timeout, and returns one response per command.
//  Sits between user command logic and SATA_CONTROLLER, in the CLK_OUT domain.
// PARAMETERS
//  TIMEOUT_CYCLES  32'd150_000_000  max clk cycles from COMMAND write to IPF
//  ADDR_FEAT       5'h01            FEATURES shadow register address
//  ADDR_COUNT      5'h02            COUNT address
//  ADDR_LBA_L      5'h03            LBA low address
//  ADDR_LBA_M      5'h04            LBA mid address
//  ADDR_LBA_H      5'h05            LBA high address
//  ADDR_DEV        5'h06            DEVICE address
//  ADDR_CMD        5'h07            COMMAND address on write, STATUS address on read
// PORTS
//  clk            in   1   CLK_OUT of controller
//  reset          in   1   synchronous, active-high (tie to RESET_OUT)
//  cmd_valid      in   1   command request
//  cmd_ready      out  1   1 in IDLE with LINKUP=1
//  cmd_opcode     in   8   ATA command byte
//  cmd_features   in   16  {prev,curr} features
//  cmd_count      in   16  sector count
//  cmd_lba        in   48  LBA
//  cmd_device     in   8   device register value
//  cmd_dma        in   1   1 = DMA-class command
//  rsp_valid      out  1   one-cycle pulse; response fields valid
//  rsp_status     out  8   ATA STATUS byte read back (0 if not read)
//  rsp_err        out  3   0 ok, 1 device ERR bit, 2 timeout, 3 link lost, 4 link/protocol error
//  linkup         in   1   LINKUP
//  ipf            in   1   IPF
//  r_err          in   1   R_ERR
//  illegal_state  in   1   ILLEGAL_STATE
//  write_hold     in   1   WRITE_HOLD_U
//  host_write_en  out  1   HOST_WRITE_EN
//  host_read_en   out  1   HOST_READ_EN
//  host_addr_reg  out  5   HOST_ADDR_REG
//  host_data_in   out  32  HOST_DATA_IN
//  host_data_out  in   32  HOST_DATA_OUT
//  dma_rqst       out  1   DMA_RQST
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; command fields, timer and error latch cleared. Reset aborts any
//   command with no response.
//  Acceptance: cmd_valid & cmd_ready in IDLE captures all cmd_* fields, sets reg_idx=0, goes to WRITE.
//   dma_rqst <= cmd_dma on the same edge.
//  WRITE: one register per cycle, order FEAT,COUNT,LBA_L,LBA_M,LBA_H,DEV,CMD.
//   If write_hold=1: host_write_en=0 and reg_idx holds.
//   Data {16'h0,hi,lo}: FEAT={f[15:8],f[7:0]}; COUNT={c[15:8],c[7:0]}; LBA_L={l[31:24],l[7:0]};
//   LBA_M={l[39:32],l[15:8]}; LBA_H={l[47:40],l[23:16]}; DEV={8'h0,dev}; CMD={8'h0,opcode}.
//   After the CMD write is accepted: timer=0, state WAIT_IRQ.
//  WAIT_IRQ: timer increments each cycle.
//   ipf=1 -> RD_REQ.
//   timer==TIMEOUT_CYCLES-1 -> DONE with err=2.
//  RD_REQ: one cycle with host_read_en=1 and host_addr_reg=ADDR_CMD -> RD_CAP.
//  RD_CAP: rsp_status <= host_data_out[7:0] (1-cycle read latency); err=1 if bit0 set, else 0 -> DONE.
//  DONE: rsp_valid=1 for one cycle; dma_rqst<=0; -> IDLE. The next command is accepted no earlier
//   than the cycle after DONE.
//  Errors (checked every non-IDLE cycle; priority link lost > link/protocol > timeout > device):
//   linkup=0 -> DONE, err=3.
//   r_err|illegal_state -> latch err=4, go DONE immediately, skip STATUS read (rsp_status=0).
//  Simultaneous ipf and timeout expiry: ipf wins.
//  rsp_status/rsp_err hold their values until the next rsp_valid.
//  host_addr_reg/host_data_in are 0 whenever no enable is asserted.
// TESTING
//  1. READ DMA EXT 0x25, lba=48'h0000_1234_5678, count=8, no hold.
//     -> 7 back-to-back writes; LBA_L data 32'h0000_1278; dma_rqst=1 through DONE;
//     ipf after 100 cycles, status 0x50 -> rsp_err=0, rsp_status=8'h50.
//  2. write_hold=1 for 3 cycles during the LBA_M write.
//     -> that write is issued exactly once, 3 cycles late; order unchanged.
//  3. No ipf, TIMEOUT_CYCLES=16.
//     -> rsp_valid exactly 16 cycles after the CMD write cycle; rsp_err=2; no read issued.
//  4. Status 0x51 returned. -> rsp_err=1, rsp_status=8'h51.
//  5. linkup dropped in WAIT_IRQ -> rsp_err=3, dma_rqst=0.
//     Reset pulsed mid-WRITE -> all outputs 0 next cycle, no rsp_valid.
//  6. r_err and ipf in the same cycle -> rsp_err=4, host_read_en never asserted.

Source files
------------

// File: rtl/sata_cmd_sequencer.sv
// rtl/sata_cmd_sequencer.sv - one-at-a-time ATA command sequencer on the SATA controller shadow-register port
module sata_cmd_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd150_000_000,
  parameter logic [4:0]  ADDR_FEAT      = 5'h01,
  parameter logic [4:0]  ADDR_COUNT     = 5'h02,
  parameter logic [4:0]  ADDR_LBA_L     = 5'h03,
  parameter logic [4:0]  ADDR_LBA_M     = 5'h04,
  parameter logic [4:0]  ADDR_LBA_H     = 5'h05,
  parameter logic [4:0]  ADDR_DEV       = 5'h06,
  parameter logic [4:0]  ADDR_CMD       = 5'h07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [15:0] cmd_features,
  input  logic [15:0] cmd_count,
  input  logic [47:0] cmd_lba,
  input  logic [7:0]  cmd_device,
  input  logic        cmd_dma,
  output logic        rsp_valid,
  output logic [7:0]  rsp_status,
  output logic [2:0]  rsp_err,
  input  logic        linkup,
  input  logic        ipf,
  input  logic        r_err,
  input  logic        illegal_state,
  input  logic        write_hold,
  output logic        host_write_en,
  output logic        host_read_en,
  output logic [4:0]  host_addr_reg,
  output logic [31:0] host_data_in,
  input  logic [31:0] host_data_out,
  output logic        dma_rqst
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_IRQ, S_RD_REQ, S_RD_CAP, S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [7:0]   r_opcode;
  logic [15:0]  r_features;
  logic [15:0]  r_count;
  logic [47:0]  r_lba;
  logic [7:0]   r_device;
  logic [2:0]   r_reg_idx;
  logic [31:0]  r_timer;
  logic         r_dma;
  logic [7:0]   r_rsp_status;
  logic [2:0]   r_rsp_err;

  logic         w_accept;
  logic         w_write_en;
  logic         w_read_en;
  logic [4:0]   w_addr;
  logic [31:0]  w_data;
  logic         w_rsp_load;
  logic [7:0]   w_rsp_status_nxt;
  logic [2:0]   w_rsp_err_nxt;
  logic         w_link_lost;
  logic         w_proto_err;
  logic         w_unused_data;

  // Only the STATUS byte of the read word is meaningful.
  assign w_unused_data = ^host_data_out[31:8];

  assign w_link_lost = !linkup;
  assign w_proto_err = r_err || illegal_state;

  assign cmd_ready     = (r_state == S_IDLE) && linkup && !reset;
  assign rsp_valid     = (r_state == S_DONE);
  assign rsp_status    = r_rsp_status;
  assign rsp_err       = r_rsp_err;
  assign dma_rqst      = r_dma;
  assign host_write_en = w_write_en;
  assign host_read_en  = w_read_en;
  assign host_addr_reg = w_addr;
  assign host_data_in  = w_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, host bus drive and response capture decisions
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_write_en       = 1'b0;
    w_read_en        = 1'b0;
    w_addr           = 5'h00;
    w_data           = 32'h0;
    w_rsp_load       = 1'b0;
    w_rsp_status_nxt = 8'h00;
    w_rsp_err_nxt    = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!write_hold) begin
          w_write_en = 1'b1;
          case (r_reg_idx)
            3'd0:    begin w_addr = ADDR_FEAT;  w_data = {16'h0, r_features}; end
            3'd1:    begin w_addr = ADDR_COUNT; w_data = {16'h0, r_count}; end
            3'd2:    begin w_addr = ADDR_LBA_L; w_data = {16'h0, r_lba[31:24], r_lba[7:0]}; end
            3'd3:    begin w_addr = ADDR_LBA_M; w_data = {16'h0, r_lba[39:32], r_lba[15:8]}; end
            3'd4:    begin w_addr = ADDR_LBA_H; w_data = {16'h0, r_lba[47:40], r_lba[23:16]}; end
            3'd5:    begin w_addr = ADDR_DEV;   w_data = {24'h0, r_device}; end
            default: begin w_addr = ADDR_CMD;   w_data = {24'h0, r_opcode}; end
          endcase
          if (r_reg_idx == 3'd6) w_state_nxt = S_WAIT_IRQ;
        end
      end
      S_WAIT_IRQ: begin
        if (ipf) begin
          w_state_nxt = S_RD_REQ;
        end else if (r_timer == TIMEOUT_CYCLES - 32'd1) begin
          w_state_nxt   = S_DONE;
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = 3'd2;
        end
      end
      S_RD_REQ: begin
        w_read_en   = 1'b1;
        w_addr      = ADDR_CMD;
        w_state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_rsp_load       = 1'b1;
        w_rsp_status_nxt = host_data_out[7:0];
        w_rsp_err_nxt    = {2'b00, host_data_out[0]};
        w_state_nxt      = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Link or protocol trouble abandons the command at once; nothing further goes on the bus.
    if ((r_state != S_IDLE) && (r_state != S_DONE) && (w_link_lost || w_proto_err)) begin
      w_write_en       = 1'b0;
      w_read_en        = 1'b0;
      w_addr           = 5'h00;
      w_data           = 32'h0;
      w_rsp_load       = 1'b1;
      w_rsp_status_nxt = 8'h00;
      w_rsp_err_nxt    = w_link_lost ? 3'd3 : 3'd4;
      w_state_nxt      = S_DONE;
    end
  end

  // Command capture, register index, IRQ timer, DMA request and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode     <= 8'h0;
      r_features   <= 16'h0;
      r_count      <= 16'h0;
      r_lba        <= 48'h0;
      r_device     <= 8'h0;
      r_reg_idx    <= 3'd0;
      r_timer      <= 32'd0;
      r_dma        <= 1'b0;
      r_rsp_status <= 8'h0;
      r_rsp_err    <= 3'd0;
    end else begin
      if (w_accept) begin
        r_opcode   <= cmd_opcode;
        r_features <= cmd_features;
        r_count    <= cmd_count;
        r_lba      <= cmd_lba;
        r_device   <= cmd_device;
        r_reg_idx  <= 3'd0;
        r_dma      <= cmd_dma;
      end
      if (w_write_en) r_reg_idx <= r_reg_idx + 3'd1;
      // The CMD write cycle counts as cycle 0 of the IRQ window, so WAIT_IRQ starts at 1.
      if (w_write_en && (r_reg_idx == 3'd6)) r_timer <= 32'd1;
      else if (r_state == S_WAIT_IRQ)        r_timer <= r_timer + 32'd1;
      if (w_rsp_load) begin
        r_rsp_status <= w_rsp_status_nxt;
        r_rsp_err    <= w_rsp_err_nxt;
      end
      if (r_state == S_DONE) r_dma <= 1'b0;
    end
  end

endmodule
